// File: rtl/keystream_packer_if.sv
// FIFO-side write port of the keystream packer: write strobe, packed word and full flag.
interface keystream_packer_if #(
  parameter int WIDTH = 8
);
  logic             wr_enable;
  logic [WIDTH-1:0] wr_data_buffer;
  logic             fifo_full;

  modport master (output wr_enable, output wr_data_buffer, input fifo_full);
  modport slave  (input wr_enable, input wr_data_buffer, output fifo_full);
endinterface

// File: rtl/keystream_packer.sv
// Gates the trivium core, skips warm-up output and packs the serial keystream
// LSB-first into WIDTH-bit words pushed to the byte FIFO with backpressure.
module keystream_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic                 init_flag,
  input  logic                 keystream_bit,
  output logic                 gen_key,
  keystream_packer_if.master   fifo,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     byte_count
);

  localparam int BW = $clog2(WIDTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WARMUP  = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] PUSH    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-2:0] shift;
  logic [BW-1:0]    bit_cnt;
  logic             stop_pending;
  logic             last_bit;
  logic [CNT_W-1:0] count_next;
  logic             burst_end;

  assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
  assign count_next = byte_count + 1'b1;
  assign burst_end  = (burst_len != '0) && (count_next == burst_len);

  always_comb begin
    gen_key        = ena && ((state == WARMUP) || (state == COLLECT));
    fifo.wr_enable = ena && (state == PUSH) && !fifo.fifo_full;
    busy           = (state != IDLE);
    done           = ena && (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      shift               <= '0;
      bit_cnt             <= '0;
      stop_pending        <= 1'b0;
      byte_count          <= '0;
      fifo.wr_data_buffer <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            byte_count   <= '0;
            bit_cnt      <= '0;
            stop_pending <= 1'b0;
            state        <= init_flag ? WARMUP : COLLECT;
          end
        end
        WARMUP: begin
          // The core advances on the edge where init_flag first reads 0, so the
          // bit it presents there is the first valid keystream bit: keep it.
          if (stop) begin
            state <= IDLE;
          end else if (!init_flag) begin
            shift[0] <= keystream_bit;
            bit_cnt  <= BW'(1);
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (stop) stop_pending <= 1'b1;
          if (last_bit) begin
            fifo.wr_data_buffer <= {keystream_bit, shift};
            bit_cnt             <= '0;
            state               <= PUSH;
          end else begin
            shift[bit_cnt] <= keystream_bit;
            bit_cnt        <= bit_cnt + 1'b1;
          end
        end
        PUSH: begin
          if (stop) stop_pending <= 1'b1;
          if (!fifo.fifo_full) begin
            byte_count <= count_next;
            if (burst_end)                 state <= DONE;
            else if (stop_pending || stop) state <= IDLE;
            else                           state <= COLLECT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keystream_packer.sv
// Randomized scoreboard bench for keystream_packer with a simple trivium-core stand-in.
module tb_keystream_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int KS_N  = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             init_flag;
  logic             keystream_bit;
  logic             gen_key;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] byte_count;

  keystream_packer_if #(.WIDTH(WIDTH)) fifo_if ();

  keystream_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .start         (start),
    .stop          (stop),
    .burst_len     (burst_len),
    .init_flag     (init_flag),
    .keystream_bit (keystream_bit),
    .gen_key       (gen_key),
    .fifo          (fifo_if),
    .busy          (busy),
    .done          (done),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  // Core stand-in: warm-up rounds, then one keystream bit per enabled edge.
  bit     ks [KS_N];
  int     ptr = 0;
  int     warm_cnt = 0;
  int     warm_val = 0;
  logic   warm_load = 1'b0;
  logic   junk = 1'b0;
  longint cyc = 0;

  assign init_flag     = (warm_cnt > 0);
  assign keystream_bit = (warm_cnt > 0) ? junk : ks[ptr];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    junk <= 1'($urandom);
    if (warm_load) warm_cnt <= warm_val;
    else if (gen_key) begin
      if (warm_cnt > 0) warm_cnt <= warm_cnt - 1;
      else              ptr <= ptr + 1;
    end
  end

  logic [WIDTH-1:0] exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               done_seen = 0;
  logic             spacing_on = 1'b0;
  longint           last_wr = -1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (fifo_if.wr_enable) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got data 0x%0h, expected no write", fifo_if.wr_data_buffer);
          end else begin
            check("wr_data", fifo_if.wr_data_buffer, exp_q.pop_front());
          end
          if (spacing_on) begin
            if (last_wr >= 0) check("write_spacing", cyc - last_wr, WIDTH + 1);
            last_wr = cyc;
          end
          check("gen_key_during_write", gen_key, 0);
        end
        if (done) done_seen++;
        if (busy && init_flag && ena) check("gen_key_in_warmup", gen_key, 1);
      end
    end
  endtask

  task automatic run(input int burst, input int warm, input int n_exp, input int stop_bit,
                     input int full_pct, input int ena_pct, input bit stall5, input bit exp_done);
    int               base;
    int               budget;
    bit               stop_sent;
    bit               stalled;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] held;
    stop_sent = 1'b0;
    stalled   = 1'b0;
    @(negedge clk);
    base = ptr;
    for (int k = 0; k < n_exp; k++) begin
      for (int i = 0; i < WIDTH; i++) w[i] = ks[base + k * WIDTH + i];
      exp_q.push_back(w);
    end
    warm_val  = warm;
    warm_load = 1'b1;
    burst_len = CNT_W'(burst);
    ena       = 1'b1;
    fifo_if.fifo_full = 1'b0;
    @(negedge clk);
    warm_load = 1'b0;
    start     = 1'b1;
    done_seen = 0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    budget = 0;
    while (busy && budget < 3000) begin
      if (stall5 && !stalled && !gen_key && !done) begin
        held = fifo_if.wr_data_buffer;
        fifo_if.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
          #1;
          check("stall_gen_key", gen_key, 0);
          check("stall_wr_enable", fifo_if.wr_enable, 0);
          check("stall_data_stable", fifo_if.wr_data_buffer, held);
          @(negedge clk);
        end
        stalled = 1'b1;
      end
      ena   = ($urandom_range(99) < ena_pct);
      fifo_if.fifo_full = ($urandom_range(99) < full_pct);
      start = ($urandom_range(99) < 3);
      stop  = 1'b0;
      if (stop_bit >= 0 && !stop_sent && ptr == base + stop_bit) begin
        stop      = 1'b1;
        ena       = 1'b1;
        stop_sent = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    stop  = 1'b0;
    ena   = 1'b1;
    fifo_if.fifo_full = 1'b0;
    check("run_finished", busy, 0);
    check("byte_count", byte_count, n_exp);
    check("done_pulses", done_seen, exp_done ? 1 : 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int b;
    for (int i = 0; i < KS_N; i++) ks[i] = 1'($urandom);
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    #2;
    check("reset_gen_key", gen_key, 0);
    check("reset_wr_enable", fifo_if.wr_enable, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_byte_count", byte_count, 0);
    check("reset_wr_data", fifo_if.wr_data_buffer, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-word burst: 0x0D then 0xFE, nine cycles apart.
    @(negedge clk);
    base = ptr;
    begin
      bit [15:0] pat;
      pat = 16'b1111_1110_0000_1101;
      for (int i = 0; i < 16; i++) ks[base + i] = pat[i];
    end
    spacing_on = 1'b1;
    last_wr    = -1;
    run(2, 0, 2, -1, 0, 100, 1'b0, 1'b1);
    spacing_on = 1'b0;

    // Long warm-up, then FIFO stall, then stop-terminated continuous run, then ena gaps.
    run(3, 20, 3, -1, 0, 100, 1'b0, 1'b1);
    run(2, 0, 2, -1, 0, 100, 1'b1, 1'b1);
    run(0, 0, 4, 3 * WIDTH + 2, 30, 100, 1'b0, 1'b0);
    run(3, 0, 3, -1, 20, 60, 1'b0, 1'b1);

    // Reset in the middle of a word, then a clean single-word burst.
    @(negedge clk);
    base = ptr;
    burst_len = CNT_W'(1);
    ena = 1'b1;
    warm_val = 0;
    warm_load = 1'b1;
    @(negedge clk);
    warm_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (ptr != base + 5 && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("reached_mid_word", ptr - base, 5);
    rst_n = 1'b0;
    #1;
    check("abort_gen_key", gen_key, 0);
    check("abort_wr_enable", fifo_if.wr_enable, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr_data", fifo_if.wr_data_buffer, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 1, -1, 0, 100, 1'b0, 1'b1);

    // Stop during warm-up: back to idle with no write and no done.
    @(negedge clk);
    burst_len = CNT_W'(2);
    warm_val = 10;
    warm_load = 1'b1;
    done_seen = 0;
    @(negedge clk);
    warm_load = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("warmup_stop_idle", busy, 0);
    check("warmup_stop_done", done_seen, 0);
    check("warmup_stop_count", byte_count, 0);

    for (int r = 0; r < 6; r++) begin
      int bl;
      bl = $urandom_range(1, 4);
      run(bl, $urandom_range(0, 5), bl, -1, 25, 75, 1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
